// File: rtl/tl_ul_arbiter.sv
// Two-master TL-UL arbiter: round-robin A-channel grant with burst lock,
// source-bit D-channel routing and per-master outstanding request counters.
module tl_ul_arbiter #(
    parameter int unsigned BEAT_BYTES   = 4,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,

    input  logic                      m0_a_valid,
    output logic                      m0_a_ready,
    input  logic [2:0]                m0_a_opcode,
    input  logic [2:0]                m0_a_param,
    input  logic [2:0]                m0_a_size,
    input  logic [3:0]                m0_a_source,
    input  logic [31:0]               m0_a_address,
    input  logic [BEAT_BYTES-1:0]     m0_a_mask,
    input  logic [8*BEAT_BYTES-1:0]   m0_a_data,

    input  logic                      m1_a_valid,
    output logic                      m1_a_ready,
    input  logic [2:0]                m1_a_opcode,
    input  logic [2:0]                m1_a_param,
    input  logic [2:0]                m1_a_size,
    input  logic [3:0]                m1_a_source,
    input  logic [31:0]               m1_a_address,
    input  logic [BEAT_BYTES-1:0]     m1_a_mask,
    input  logic [8*BEAT_BYTES-1:0]   m1_a_data,

    output logic                      out_a_valid,
    input  logic                      out_a_ready,
    output logic [2:0]                out_a_opcode,
    output logic [2:0]                out_a_param,
    output logic [2:0]                out_a_size,
    output logic [4:0]                out_a_source,
    output logic [31:0]               out_a_address,
    output logic [BEAT_BYTES-1:0]     out_a_mask,
    output logic [8*BEAT_BYTES-1:0]   out_a_data,

    input  logic                      out_d_valid,
    output logic                      out_d_ready,
    input  logic [2:0]                out_d_opcode,
    input  logic [1:0]                out_d_param,
    input  logic [2:0]                out_d_size,
    input  logic [4:0]                out_d_source,
    input  logic                      out_d_sink,
    input  logic                      out_d_denied,
    input  logic                      out_d_corrupt,
    input  logic [8*BEAT_BYTES-1:0]   out_d_data,

    output logic                      m0_d_valid,
    input  logic                      m0_d_ready,
    output logic [2:0]                m0_d_opcode,
    output logic [1:0]                m0_d_param,
    output logic [2:0]                m0_d_size,
    output logic [3:0]                m0_d_source,
    output logic                      m0_d_sink,
    output logic                      m0_d_denied,
    output logic                      m0_d_corrupt,
    output logic [8*BEAT_BYTES-1:0]   m0_d_data,

    output logic                      m1_d_valid,
    input  logic                      m1_d_ready,
    output logic [2:0]                m1_d_opcode,
    output logic [1:0]                m1_d_param,
    output logic [2:0]                m1_d_size,
    output logic [3:0]                m1_d_source,
    output logic                      m1_d_sink,
    output logic                      m1_d_denied,
    output logic                      m1_d_corrupt,
    output logic [8*BEAT_BYTES-1:0]   m1_d_data,

    output logic [2:0]                inflight0,
    output logic [2:0]                inflight1,
    output logic                      busy
);

    localparam int unsigned CW      = 8;
    localparam int unsigned BLG     = $clog2(BEAT_BYTES);
    localparam logic [2:0]  MAX_CNT = 3'(MAX_INFLIGHT);

    typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_gnt, w_gnt_nxt;
    logic [CW-1:0] r_a_cnt, w_a_cnt_nxt;
    logic [CW-1:0] r_d_cnt;
    logic          r_rr, r_pend, r_pend_idx;
    logic [2:0]    r_inflight0, r_inflight1;

    logic w_elig0, w_elig1, w_idx, w_grant_ok;
    logic w_a_fire, w_a_first, w_a_multi;
    logic w_d_to1, w_d_fire, w_d_multi, w_d_last;

    function automatic logic [CW-1:0] f_bytes(input logic [2:0] size);
        return CW'(1) << size;
    endfunction

    function automatic logic [2:0] f_count(input logic [2:0] cnt, input logic inc, input logic dec);
        if (inc && !dec && cnt != MAX_CNT) return cnt + 3'd1;
        if (dec && !inc && cnt != 3'd0)     return cnt - 3'd1;
        return cnt;
    endfunction

    assign w_elig0 = m0_a_valid && (r_inflight0 < MAX_CNT);
    assign w_elig1 = m1_a_valid && (r_inflight1 < MAX_CNT);

    // A pending (valid, not yet fired) grant is frozen so the beat stays stable.
    always_comb begin
        w_idx      = 1'b0;
        w_grant_ok = 1'b0;
        if (r_state == S_LOCKED) begin
            w_idx      = r_gnt;
            w_grant_ok = 1'b1;
        end else if (r_pend) begin
            w_idx      = r_pend_idx;
            w_grant_ok = 1'b1;
        end else begin
            w_idx      = (w_elig0 && w_elig1) ? r_rr : w_elig1;
            w_grant_ok = w_elig0 | w_elig1;
        end
    end

    assign out_a_valid   = reset_n & w_grant_ok & (w_idx ? m1_a_valid : m0_a_valid);
    assign out_a_opcode  = w_idx ? m1_a_opcode  : m0_a_opcode;
    assign out_a_param   = w_idx ? m1_a_param   : m0_a_param;
    assign out_a_size    = w_idx ? m1_a_size    : m0_a_size;
    assign out_a_source  = {w_idx, (w_idx ? m1_a_source : m0_a_source)};
    assign out_a_address = w_idx ? m1_a_address : m0_a_address;
    assign out_a_mask    = w_idx ? m1_a_mask    : m0_a_mask;
    assign out_a_data    = w_idx ? m1_a_data    : m0_a_data;
    assign m0_a_ready    = reset_n & w_grant_ok & ~w_idx & out_a_ready;
    assign m1_a_ready    = reset_n & w_grant_ok &  w_idx & out_a_ready;

    assign w_a_fire  = out_a_valid & out_a_ready;
    assign w_a_first = w_a_fire & (r_state == S_IDLE);
    assign w_a_multi = ((out_a_opcode == 3'd0) || (out_a_opcode == 3'd1)) &&
                       (f_bytes(out_a_size) > CW'(BEAT_BYTES));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_a_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_a_cnt <= w_a_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_a_cnt_nxt = r_a_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_a_first && w_a_multi) begin
                    w_state_nxt = S_LOCKED;
                    w_gnt_nxt   = w_idx;
                    w_a_cnt_nxt = (f_bytes(out_a_size) >> BLG) - CW'(1);
                end
            end
            S_LOCKED: begin
                if (w_a_fire) begin
                    w_a_cnt_nxt = r_a_cnt - CW'(1);
                    if (r_a_cnt == CW'(1)) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rr       <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_idx <= 1'b0;
        end else begin
            if (w_a_first) r_rr <= ~w_idx;
            r_pend     <= (r_state == S_IDLE) && out_a_valid && !out_a_ready;
            r_pend_idx <= w_idx;
        end
    end

    // D routing is per beat; the counter only locates the last beat.
    assign w_d_to1      = out_d_source[4];
    assign m0_d_valid   = reset_n & out_d_valid & ~w_d_to1;
    assign m1_d_valid   = reset_n & out_d_valid &  w_d_to1;
    assign out_d_ready  = reset_n & (w_d_to1 ? m1_d_ready : m0_d_ready);
    assign m0_d_opcode  = out_d_opcode;
    assign m0_d_param   = out_d_param;
    assign m0_d_size    = out_d_size;
    assign m0_d_source  = out_d_source[3:0];
    assign m0_d_sink    = out_d_sink;
    assign m0_d_denied  = out_d_denied;
    assign m0_d_corrupt = out_d_corrupt;
    assign m0_d_data    = out_d_data;
    assign m1_d_opcode  = out_d_opcode;
    assign m1_d_param   = out_d_param;
    assign m1_d_size    = out_d_size;
    assign m1_d_source  = out_d_source[3:0];
    assign m1_d_sink    = out_d_sink;
    assign m1_d_denied  = out_d_denied;
    assign m1_d_corrupt = out_d_corrupt;
    assign m1_d_data    = out_d_data;

    assign w_d_fire  = out_d_valid & out_d_ready;
    assign w_d_multi = (out_d_opcode == 3'd1) && (f_bytes(out_d_size) > CW'(BEAT_BYTES));
    assign w_d_last  = w_d_fire & ((r_d_cnt == '0) ? ~w_d_multi : (r_d_cnt == CW'(1)));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_d_cnt <= '0;
        end else if (w_d_fire) begin
            if (r_d_cnt == '0) begin
                if (w_d_multi) r_d_cnt <= (f_bytes(out_d_size) >> BLG) - CW'(1);
            end else begin
                r_d_cnt <= r_d_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_inflight0 <= 3'd0;
            r_inflight1 <= 3'd0;
        end else begin
            r_inflight0 <= f_count(r_inflight0, w_a_first & ~w_idx, w_d_last & ~w_d_to1);
            r_inflight1 <= f_count(r_inflight1, w_a_first &  w_idx, w_d_last &  w_d_to1);
        end
    end

    assign inflight0 = r_inflight0;
    assign inflight1 = r_inflight1;
    assign busy      = (r_state == S_LOCKED) | (r_inflight0 != 3'd0) | (r_inflight1 != 3'd0);

endmodule

// File: tb/tb_tl_ul_arbiter.sv
// Directed bench for tl_ul_arbiter: arbitration, burst lock, D routing,
// inflight accounting and reset behaviour with hand-computed expectations.
module tb_tl_ul_arbiter;

    localparam logic [2:0] OP_PUTF = 3'd0;
    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] OP_ACK  = 3'd0;
    localparam logic [2:0] OP_ACKD = 3'd1;

    logic clock = 1'b0;
    logic reset_n;

    logic        m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
    logic [2:0]  m0_a_opcode, m0_a_param, m0_a_size, m1_a_opcode, m1_a_param, m1_a_size;
    logic [3:0]  m0_a_source, m1_a_source, m0_a_mask, m1_a_mask;
    logic [31:0] m0_a_address, m1_a_address, m0_a_data, m1_a_data;

    logic        out_a_valid, out_a_ready;
    logic [2:0]  out_a_opcode, out_a_param, out_a_size;
    logic [4:0]  out_a_source;
    logic [31:0] out_a_address, out_a_data;
    logic [3:0]  out_a_mask;

    logic        out_d_valid, out_d_ready, out_d_sink, out_d_denied, out_d_corrupt;
    logic [2:0]  out_d_opcode, out_d_size;
    logic [1:0]  out_d_param;
    logic [4:0]  out_d_source;
    logic [31:0] out_d_data;

    logic        m0_d_valid, m0_d_ready, m0_d_sink, m0_d_denied, m0_d_corrupt;
    logic        m1_d_valid, m1_d_ready, m1_d_sink, m1_d_denied, m1_d_corrupt;
    logic [2:0]  m0_d_opcode, m0_d_size, m1_d_opcode, m1_d_size;
    logic [1:0]  m0_d_param, m1_d_param;
    logic [3:0]  m0_d_source, m1_d_source;
    logic [31:0] m0_d_data, m1_d_data;

    logic [2:0]  inflight0, inflight1;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    tl_ul_arbiter #(.BEAT_BYTES(4), .MAX_INFLIGHT(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
        .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
        .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
        .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
        .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt),
        .out_d_data(out_d_data),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
        .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
        .m0_d_sink(m0_d_sink), .m0_d_denied(m0_d_denied), .m0_d_corrupt(m0_d_corrupt),
        .m0_d_data(m0_d_data),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
        .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
        .m1_d_sink(m1_d_sink), .m1_d_denied(m1_d_denied), .m1_d_corrupt(m1_d_corrupt),
        .m1_d_data(m1_d_data),
        .inflight0(inflight0), .inflight1(inflight1), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m0a(input logic v, input logic [2:0] op, input logic [2:0] sz,
                       input logic [3:0] src, input logic [31:0] dat);
        m0_a_valid = v; m0_a_opcode = op; m0_a_param = 3'd0; m0_a_size = sz;
        m0_a_source = src; m0_a_address = 32'h1000_0000 | 32'(src); m0_a_mask = 4'hf;
        m0_a_data = dat;
    endtask

    task automatic m1a(input logic v, input logic [2:0] op, input logic [2:0] sz,
                       input logic [3:0] src, input logic [31:0] dat);
        m1_a_valid = v; m1_a_opcode = op; m1_a_param = 3'd0; m1_a_size = sz;
        m1_a_source = src; m1_a_address = 32'h2000_0000 | 32'(src); m1_a_mask = 4'hf;
        m1_a_data = dat;
    endtask

    task automatic dch(input logic v, input logic [2:0] op, input logic [2:0] sz,
                       input logic [4:0] src, input logic [31:0] dat);
        out_d_valid = v; out_d_opcode = op; out_d_param = 2'd0; out_d_size = sz;
        out_d_source = src; out_d_sink = 1'b0; out_d_denied = 1'b0; out_d_corrupt = 1'b0;
        out_d_data = dat;
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        out_a_ready = 1'b1;
        m0_d_ready = 1'b1;
        m1_d_ready = 1'b1;
        m0a(1'b1, OP_GET, 3'd2, 4'h2, 32'h0);
        m1a(1'b0, OP_GET, 3'd2, 4'h0, 32'h0);
        dch(1'b1, OP_ACKD, 3'd2, 5'h01, 32'h0);
        #1;
        chk("rst_m0_a_ready", 32'(m0_a_ready), 32'd0);
        chk("rst_out_a_valid", 32'(out_a_valid), 32'd0);
        chk("rst_m0_d_valid", 32'(m0_d_valid), 32'd0);
        chk("rst_out_d_ready", 32'(out_d_ready), 32'd0);
        next(); next();
        chk("rst_inflight0", 32'(inflight0), 32'd0);
        chk("rst_inflight1", 32'(inflight1), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        dch(1'b0, OP_ACK, 3'd2, 5'h00, 32'h0);

        // Round robin between simultaneous Gets
        m0a(1'b1, OP_GET, 3'd2, 4'h2, 32'h0);
        m1a(1'b1, OP_GET, 3'd2, 4'h7, 32'h0);
        #1;
        chk("rr_out_a_valid", 32'(out_a_valid), 32'd1);
        chk("rr_first_src", 32'(out_a_source), 32'h02);
        chk("rr_first_m0_ready", 32'(m0_a_ready), 32'd1);
        chk("rr_first_m1_ready", 32'(m1_a_ready), 32'd0);
        chk("rr_first_addr", out_a_address, 32'h1000_0002);
        next();
        m0a(1'b0, OP_GET, 3'd2, 4'h2, 32'h0);
        #1;
        chk("rr_second_src", 32'(out_a_source), 32'h17);
        chk("rr_second_m1_ready", 32'(m1_a_ready), 32'd1);
        chk("rr_second_m0_ready", 32'(m0_a_ready), 32'd0);
        chk("rr_inflight0", 32'(inflight0), 32'd1);
        next();
        m0a(1'b1, OP_GET, 3'd2, 4'h2, 32'h0);
        m1a(1'b1, OP_GET, 3'd2, 4'h7, 32'h0);
        out_a_ready = 1'b0;
        #1;
        chk("rr_back_src", 32'(out_a_source), 32'h02);
        chk("rr_inflight1", 32'(inflight1), 32'd1);
        chk("rr_busy", 32'(busy), 32'd1);
        next();
        m0a(1'b0, OP_GET, 3'd2, 4'h2, 32'h0);
        m1a(1'b0, OP_GET, 3'd2, 4'h7, 32'h0);
        out_a_ready = 1'b1;

        // Two-beat AccessAckData routed to m1
        dch(1'b1, OP_ACKD, 3'd3, 5'h15, 32'hD0D0_0001);
        #1;
        chk("d_b1_m1_valid", 32'(m1_d_valid), 32'd1);
        chk("d_b1_m0_valid", 32'(m0_d_valid), 32'd0);
        chk("d_b1_m1_source", 32'(m1_d_source), 32'h5);
        chk("d_b1_m1_data", m1_d_data, 32'hD0D0_0001);
        chk("d_b1_out_d_ready", 32'(out_d_ready), 32'd1);
        next();
        dch(1'b1, OP_ACKD, 3'd3, 5'h15, 32'hD0D0_0002);
        #1;
        chk("d_b1_inflight1", 32'(inflight1), 32'd1);
        chk("d_b2_m1_valid", 32'(m1_d_valid), 32'd1);
        chk("d_b2_m1_data", m1_d_data, 32'hD0D0_0002);
        next();
        dch(1'b0, OP_ACK, 3'd2, 5'h00, 32'h0);
        chk("d_b2_inflight1", 32'(inflight1), 32'd0);
        chk("d_b2_inflight0", 32'(inflight0), 32'd1);

        // Point rr at m1, then 4-beat PutFullData from m1 against an m0 Get
        m0a(1'b1, OP_GET, 3'd2, 4'h1, 32'h0);
        #1;
        chk("prep_m0_ready", 32'(m0_a_ready), 32'd1);
        next();
        m1a(1'b1, OP_PUTF, 3'd4, 4'h3, 32'hB000_0000);
        #1;
        chk("lk_b1_src", 32'(out_a_source), 32'h13);
        chk("lk_b1_m1_ready", 32'(m1_a_ready), 32'd1);
        chk("lk_b1_m0_ready", 32'(m0_a_ready), 32'd0);
        chk("lk_b1_opcode", 32'(out_a_opcode), 32'(OP_PUTF));
        next();
        m1a(1'b1, OP_PUTF, 3'd4, 4'h3, 32'hB000_0001);
        #1;
        chk("lk_b2_src", 32'(out_a_source), 32'h13);
        chk("lk_b2_m0_ready", 32'(m0_a_ready), 32'd0);
        chk("lk_b2_data", out_a_data, 32'hB000_0001);
        chk("lk_b2_busy", 32'(busy), 32'd1);
        chk("lk_b2_inflight1", 32'(inflight1), 32'd1);
        next();
        m1a(1'b1, OP_PUTF, 3'd4, 4'h3, 32'hB000_0002);
        out_a_ready = 1'b0;
        #1;
        chk("lk_stall_m1_ready", 32'(m1_a_ready), 32'd0);
        chk("lk_stall_valid", 32'(out_a_valid), 32'd1);
        chk("lk_stall_src", 32'(out_a_source), 32'h13);
        next();
        out_a_ready = 1'b1;
        #1;
        chk("lk_b3_m1_ready", 32'(m1_a_ready), 32'd1);
        chk("lk_b3_m0_ready", 32'(m0_a_ready), 32'd0);
        chk("lk_b3_data", out_a_data, 32'hB000_0002);
        next();
        m1a(1'b1, OP_PUTF, 3'd4, 4'h3, 32'hB000_0003);
        #1;
        chk("lk_b4_m1_ready", 32'(m1_a_ready), 32'd1);
        chk("lk_b4_m0_ready", 32'(m0_a_ready), 32'd0);
        next();
        m1a(1'b0, OP_PUTF, 3'd4, 4'h3, 32'h0);
        #1;
        chk("post_lk_src", 32'(out_a_source), 32'h01);
        chk("post_lk_m0_ready", 32'(m0_a_ready), 32'd1);
        next();
        m0a(1'b0, OP_GET, 3'd2, 4'h1, 32'h0);
        chk("post_lk_inflight0", 32'(inflight0), 32'd3);

        reset_n = 1'b0;
        next();
        reset_n = 1'b1;
        chk("rst2_inflight0", 32'(inflight0), 32'd0);
        chk("rst2_inflight1", 32'(inflight1), 32'd0);

        // Fill m0 to MAX_INFLIGHT with Gets
        for (int i = 0; i < 4; i++) begin
            m0a(1'b1, OP_GET, 3'd2, 4'(i), 32'h0);
            #1;
            chk($sformatf("fill_%0d_m0_ready", i), 32'(m0_a_ready), 32'd1);
            next();
        end
        m0a(1'b1, OP_GET, 3'd2, 4'h4, 32'h0);
        m1a(1'b1, OP_GET, 3'd2, 4'h9, 32'h0);
        #1;
        chk("full_inflight0", 32'(inflight0), 32'd4);
        chk("full_m0_ready", 32'(m0_a_ready), 32'd0);
        chk("full_src", 32'(out_a_source), 32'h19);
        chk("full_m1_ready", 32'(m1_a_ready), 32'd1);
        next();
        m1a(1'b0, OP_GET, 3'd2, 4'h9, 32'h0);
        dch(1'b1, OP_ACKD, 3'd2, 5'h03, 32'h0000_0033);
        #1;
        chk("full_out_a_valid", 32'(out_a_valid), 32'd0);
        chk("full_m0_ready2", 32'(m0_a_ready), 32'd0);
        chk("ack_m0_d_valid", 32'(m0_d_valid), 32'd1);
        chk("ack_m0_d_source", 32'(m0_d_source), 32'h3);
        next();
        // Same-cycle A first beat and D last beat for m0
        dch(1'b1, OP_ACK, 3'd2, 5'h00, 32'h0);
        #1;
        chk("ack_inflight0", 32'(inflight0), 32'd3);
        chk("same_m0_a_ready", 32'(m0_a_ready), 32'd1);
        chk("same_m0_d_valid", 32'(m0_d_valid), 32'd1);
        chk("same_out_d_ready", 32'(out_d_ready), 32'd1);
        next();
        m0a(1'b0, OP_GET, 3'd2, 4'h4, 32'h0);
        dch(1'b0, OP_ACK, 3'd2, 5'h00, 32'h0);
        chk("same_inflight0", 32'(inflight0), 32'd3);

        // Two responses to m1 with one outstanding: count floors at zero
        dch(1'b1, OP_ACK, 3'd2, 5'h10, 32'h0);
        next();
        chk("sat_inflight1_a", 32'(inflight1), 32'd0);
        next();
        dch(1'b0, OP_ACK, 3'd2, 5'h00, 32'h0);
        chk("sat_inflight1_b", 32'(inflight1), 32'd0);

        // Reset in the middle of a 4-beat burst from m0
        m0a(1'b1, OP_PUTF, 3'd4, 4'h6, 32'hC000_0000);
        #1;
        chk("rb_b1_m0_ready", 32'(m0_a_ready), 32'd1);
        next();
        m0a(1'b1, OP_PUTF, 3'd4, 4'h6, 32'hC000_0001);
        #1;
        chk("rb_b2_src", 32'(out_a_source), 32'h06);
        chk("rb_b2_busy", 32'(busy), 32'd1);
        next();
        reset_n = 1'b0;
        m0a(1'b1, OP_GET, 3'd2, 4'h8, 32'h0);
        m1a(1'b1, OP_GET, 3'd2, 4'hA, 32'h0);
        #1;
        chk("rb_rst_valid", 32'(out_a_valid), 32'd0);
        chk("rb_rst_m1_ready", 32'(m1_a_ready), 32'd0);
        next();
        reset_n = 1'b1;
        #1;
        chk("rb_inflight0", 32'(inflight0), 32'd0);
        chk("rb_inflight1", 32'(inflight1), 32'd0);
        chk("rb_busy", 32'(busy), 32'd0);
        chk("rb_src", 32'(out_a_source), 32'h08);
        chk("rb_opcode", 32'(out_a_opcode), 32'(OP_GET));
        chk("rb_m0_ready", 32'(m0_a_ready), 32'd1);
        chk("rb_m1_ready", 32'(m1_a_ready), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
